// File: rtl/pipe_pkg.sv
// Shared write-back pipeline types: the payload carried between the
// memory and write-back stages, and its packed width.
package pipe_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wreg;
        logic        mem2reg;
        logic [31:0] data;
        logic [2:0]  func3;
    } wb_payload_t;

    localparam int WB_PAYLOAD_W = 42;

endpackage

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline register with flush, occupancy report
// and a saturating downstream-stall counter. Payload-agnostic (DATA_W bits).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = WB_PAYLOAD_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_main_valid;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [1:0]        r_occupancy;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_main_valid_nxt;
    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_accept;
    logic              w_pop;
    logic              w_stall;

    // in_ready comes straight from the skid flag, so upstream never sees
    // a combinational path from out_ready.
    assign in_ready  = ~r_skid_valid;
    assign w_accept  = in_valid & ~r_skid_valid;
    assign w_pop     = r_main_valid & out_ready;
    assign w_stall   = r_main_valid & ~out_ready;

    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;
    assign occupancy = r_occupancy;
    assign stall_cnt = r_stall_cnt;

    always_comb begin
        // NOTE: every target gets a default first so no path through the
        // case analysis leaves a signal unassigned and infers a latch.
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_main_data_nxt  = r_main_data;
        w_skid_data_nxt  = r_skid_data;

        if (flush) begin
            // NOTE: payloads are zeroed whenever an entry goes invalid so a
            // bubble on out_data is the all-zero NOP encoding.
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
            w_main_data_nxt  = '0;
            w_skid_data_nxt  = '0;
        end else if (!r_main_valid) begin
            if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_main_data_nxt  = in_data;
            end
        end else if (!r_skid_valid) begin
            if (w_pop && w_accept) begin
                w_main_data_nxt  = in_data;
            end else if (w_accept) begin
                w_skid_valid_nxt = 1'b1;
                w_skid_data_nxt  = in_data;
            end else if (w_pop) begin
                w_main_valid_nxt = 1'b0;
                w_main_data_nxt  = '0;
            end
        end else if (w_pop) begin
            w_main_data_nxt  = r_skid_data;
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_occupancy  <= 2'd0;
            r_stall_cnt  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_main_data  <= w_main_data_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
            // Stall counting is independent of flush and saturates at all-ones.
            if (w_stall && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus random
// traffic, compared every cycle against a queue-based FIFO model.
module tb_pipe_stage_reg;

    localparam int DW = 42;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;

    logic          in_ready2, out_valid2;
    logic [DW-1:0] out_data2;
    logic [1:0]    occupancy2;
    logic [1:0]    stall_cnt2;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] seen[$];
    int            cnt;
    int            cnt2;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .occupancy(occupancy2), .stall_cnt(stall_cnt2)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model, then advance model and DUT one edge.
    task automatic tick();
        logic [DW-1:0] head;
        bit acc, pop, stall;
        head = (q.size() > 0) ? q[0] : '0;
        check_eq("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check_eq("out_data", 64'(out_data), 64'(head));
        check_eq("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check_eq("occupancy", 64'(occupancy), 64'(q.size()));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(cnt));
        check_eq("stall_cnt_w2", 64'(stall_cnt2), 64'(cnt2));
        check_eq("out_data_w2", 64'(out_data2), 64'(head));

        if (!rst && !flush && out_valid && out_ready) seen.push_back(out_data);

        acc   = in_valid && (q.size() < 2);
        pop   = (q.size() > 0) && out_ready;
        stall = (q.size() > 0) && !out_ready;
        if (rst) begin
            q.delete();
            cnt  = 0;
            cnt2 = 0;
        end else begin
            if (stall) begin
                if (cnt < 65535) cnt++;
                if (cnt2 < 3) cnt2++;
            end
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    endtask

    initial begin
        int exp_sat[6] = '{1, 2, 3, 3, 3, 3};
        logic [63:0] rnd;

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0; cnt2 = 0;
        tick();
        rst = 1'b0;

        // Reset values.
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_data", 64'(out_data), 64'd0);

        // Idle 3 cycles, then single entry with latency 1.
        repeat (3) tick();
        in_valid = 1'b1; in_data = 42'h2A5; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("lat1_valid", 64'(out_valid), 64'd1);
        check_eq("lat1_data", 64'(out_data), 64'h2A5);
        check_eq("lat1_occ", 64'(occupancy), 64'd1);
        tick();

        // Back-to-back stream of 1..8 with downstream always ready.
        seen.delete();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            tick();
            check_eq("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check_eq("stream_count", 64'(seen.size()), 64'd8);
        for (int i = 0; i < seen.size(); i++) check_eq("stream_order", 64'(seen[i]), 64'(i + 1));
        check_eq("stream_stall", 64'(stall_cnt), 64'd0);

        // Backpressure: 1 and 2 buffered, 3 held upstream, then drained in order.
        seen.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 42'd1; tick();
        in_data = 42'd2; tick();
        in_data = 42'd3; tick();
        check_eq("bp_occ", 64'(occupancy), 64'd2);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 6 && in_valid; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        check_eq("bp_hold_bound", 64'(in_valid), 64'd0);
        repeat (3) tick();
        check_eq("bp_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < seen.size(); i++) check_eq("bp_order", 64'(seen[i]), 64'(i + 1));
        check_eq("bp_stall", 64'(stall_cnt), 64'd2);

        // Flush with both entries full and a same-cycle offer of 0x7.
        seen.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 42'h11; tick();
        in_data = 42'h22; tick();
        check_eq("fl_full", 64'(occupancy), 64'd2);
        flush = 1'b1; in_valid = 1'b1; in_data = 42'h7; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("fl_occ", 64'(occupancy), 64'd0);
        check_eq("fl_valid", 64'(out_valid), 64'd0);
        check_eq("fl_data", 64'(out_data), 64'd0);
        check_eq("fl_in_ready", 64'(in_ready), 64'd1);
        check_eq("fl_stall_kept", 64'(stall_cnt), 64'd3);
        repeat (3) tick();
        check_eq("fl_no_output", 64'(seen.size()), 64'd0);

        // Saturation of a 2-bit stall counter.
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 42'h55; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("sat_cnt", 64'(stall_cnt2), 64'(exp_sat[i]));
        end

        // Reset while full with stall_cnt=5.
        rst = 1'b1; tick(); rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 42'hA; tick();
        in_data = 42'hB; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10 && cnt < 5; i++) tick();
        check_eq("pre_rst_occ", 64'(occupancy), 64'd2);
        check_eq("pre_rst_stall", 64'(stall_cnt), 64'd5);
        rst = 1'b1; in_valid = 1'b1; in_data = 42'hC; out_ready = 1'b1; tick();
        idle_inputs();
        check_eq("rst2_valid", 64'(out_valid), 64'd0);
        check_eq("rst2_data", 64'(out_data), 64'd0);
        check_eq("rst2_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst2_occ", 64'(occupancy), 64'd0);
        check_eq("rst2_stall", 64'(stall_cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rnd       = {$urandom(), $urandom()};
            in_data   = rnd[DW-1:0];
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 127) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
